circuit_checker: RTL
====================

Name: circuit_checker

Overview:
- Stimulus driver and self-checker for the two-input gate circuit (a, b -> c, c_ideal); it sits on the opposite end of that interface.
- On a start pulse it sweeps all four (a,b) patterns NUM_ROUNDS times.
- For each pattern it waits a settle window, then compares c against c_ideal.
- It counts mismatches, records the first failing pattern, and reports pass/fail at the end.

Parameters:
- SETTLE_CYCLES, 2: cycles a pattern is held before sampling (legal range 1..15).
- NUM_ROUNDS, 1: full 4-pattern sweeps per run (legal range 1..255).
- ERR_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored unless the FSM is in IDLE or DONE.
- a  out  1  stimulus bit a to the circuit under check.
- b  out  1  stimulus bit b to the circuit under check.
- c  in  1  circuit output.
- c_ideal  in  1  golden output.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  high in DONE; stays high until the next start or reset.
- pass  out  1  valid while done; 1 iff err_count == 0.
- err_count  out  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- first_fail  out  2  {a,b} of the first mismatch; valid when err_count != 0.

Behaviour:
- Reset (rst_n low at a clk edge): FSM=IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, pattern=0, round=0, timer=0. Reset mid-run aborts immediately; no partial result is kept.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start:
  - go to DRIVE; pattern=0; round=0.
  - clear err_count, first_fail, done, pass.
  - load timer=SETTLE_CYCLES-1.
  - busy=1.
- DRIVE:
  - {a,b}=pattern, registered; they change only on entry to DRIVE.
  - Each cycle the timer decrements; at timer==0, go to SAMPLE.
  - DRIVE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE:
  - Lasts one cycle; {a,b} is held. Compare c vs c_ideal.
  - On mismatch: err_count+1, saturating. If err_count was 0, first_fail=pattern.
  - Then:
    - pattern<3: pattern+1, reload timer, go to DRIVE.
    - pattern==3 and round<NUM_ROUNDS-1: pattern=0, round+1, go to DRIVE.
    - otherwise: go to DONE.
- DONE:
  - busy=0, done=1, pass=(err_count==0). a, b return to 0.
  - Results hold until start or reset.
- Latency:
  - Each pattern takes SETTLE_CYCLES+1 cycles.
  - done rises 4*NUM_ROUNDS*(SETTLE_CYCLES+1)+1 cycles after the start edge. With defaults this is 13.
- Boundary and simultaneous events:
  - start during DRIVE/SAMPLE is ignored.
  - start in DONE restarts the run and clears results in the same edge.
  - The counter saturates at all-ones and does not wrap.
  - Sampling uses the values of c and c_ideal at the SAMPLE-state edge only.

Optional Feature:
- Macro: CIRCUIT_CHECKER_FAILMAP_EN.
- Defined:
  - Adds output fail_map[3:0]; bit k sets if pattern k ever mismatched.
  - Cleared on reset and on accepted start; sticky across rounds.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package circuit_checker_pkg holds:
  - state typedef (IDLE, DRIVE, SAMPLE, DONE);
  - constant NUM_PATTERNS=4;
  - constant PAT_W=2.
- Sub-module checker_settle_timer: loadable down-counter with load, value and zero-flag.
- Pattern/round counters and the compare logic stay in the top level.

Test Plan:
- Correct circuit (c = c_ideal = (a&b)|b), defaults, start pulse -> {a,b} sequence 00,01,10,11, each held 3 cycles; done at cycle 13; pass=1; err_count=0.
- c stuck-at-0 -> mismatches on 01 and 11; err_count=2; first_fail=2'b01; pass=0; fail_map=4'b1010 (if enabled).
- c stuck-at-1, NUM_ROUNDS=3 -> mismatches on 00 and 10 each round; err_count=6; first_fail=2'b00; done at cycle 37.
- ERR_W=2, c inverted, NUM_ROUNDS=2 -> 8 raw mismatches; err_count saturates at 3; pass=0.
- rst_n low during pattern 10 of a run -> next edge: all outputs at reset values, FSM=IDLE. A following start runs cleanly to pass=1.
- start pulsed during DRIVE at cycle 5 -> ignored, timing unchanged, done at cycle 13. start in DONE -> results cleared and the new run begins.

Source files
------------

// File: rtl/circuit_checker_pkg.sv
// Shared types and constants for the circuit_checker stimulus/check block.
package circuit_checker_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int NUM_PATTERNS = 4;
  localparam int PAT_W        = 2;
  localparam int TIMER_W      = 4;

endpackage

// File: rtl/checker_settle_timer.sv
// Loadable down-counter that times how long each stimulus pattern settles.
module checker_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/circuit_checker.sv
// Sweeps all (a,b) patterns over a gate circuit and compares c against c_ideal.
// Optional fail_map output enabled by defining CIRCUIT_CHECKER_FAILMAP_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | {a,b} applied, settle timer running
// SAMPLE | one cycle: compare c vs c_ideal, advance pattern/round
// DONE   | results held until next start
module circuit_checker
  import circuit_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_ROUNDS    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  input  logic             c_ideal,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [PAT_W-1:0] first_fail
`ifdef CIRCUIT_CHECKER_FAILMAP_EN
  ,
  output logic [NUM_PATTERNS-1:0] fail_map
`endif
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]         LAST_ROUND  = 8'(NUM_ROUNDS - 1);
  localparam logic [PAT_W-1:0]   LAST_PAT    = PAT_W'(NUM_PATTERNS - 1);

  state_t             state;
  logic [PAT_W-1:0]   pattern;
  logic [7:0]         round;
  logic               start_ok;
  logic               timer_zero;
  logic [TIMER_W-1:0] unused_timer_value;

  assign start_ok = start && (state == IDLE || state == DONE);

  // Reload happens on every accepted start and on every SAMPLE cycle.
  checker_settle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_ok || state == SAMPLE),
    .load_value (SETTLE_LOAD),
    .dec        (state == DRIVE),
    .value      (unused_timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      pattern    <= '0;
      round      <= '0;
`ifdef CIRCUIT_CHECKER_FAILMAP_EN
      fail_map   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            pattern    <= '0;
            round      <= '0;
            err_count  <= '0;
            first_fail <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            {a, b}     <= '0;
`ifdef CIRCUIT_CHECKER_FAILMAP_EN
            fail_map   <= '0;
`endif
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0);
          end
        end
        DRIVE: begin
          if (timer_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          if (c != c_ideal) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_fail <= pattern;
`ifdef CIRCUIT_CHECKER_FAILMAP_EN
            fail_map[pattern] <= 1'b1;
`endif
          end
          if (pattern != LAST_PAT) begin
            pattern <= pattern + 1'b1;
            {a, b}  <= pattern + 1'b1;
            state   <= DRIVE;
          end else if (round < LAST_ROUND) begin
            pattern <= '0;
            round   <= round + 1'b1;
            {a, b}  <= '0;
            state   <= DRIVE;
          end else begin
            {a, b} <= '0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
